// File: rtl/riscv_pkg.sv
// Shared definitions for the write-back slice.
// Contents:
//   XLEN     - data width
//   REG_AW   - register address width (x0 is hardwired zero)
//   NREG     - number of architectural registers
//   LQ_DEPTH - maximum outstanding loads (power of 2, >= 2)
//   wb_src_t - execute-stage write-back source select
package riscv_pkg;

  localparam int XLEN     = 16;
  localparam int REG_AW   = 3;
  localparam int NREG     = 2 ** REG_AW;
  localparam int LQ_DEPTH = 4;

  typedef enum logic [1:0] {
    WB_ALU          = 2'd0,
    WB_MEM          = 2'd1,
    WB_PC_PLUS_FOUR = 2'd2
  } wb_src_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of every non-clock/reset signal around the write-back arbiter.
// Modports:
//   slave  - the arbiter's view: execute/load inputs in; ready, register-file
//            write, busy map and error out
//   master - the environment's view (execute stage, load unit, register file)
// Signal groups:
//   ex_*       execute-stage result handshake (valid/ready)
//   ld_issue_* load issue into the tag queue
//   ld_resp_*  in-order load data returning from memory
//   rf_*       registered register-file write port
//   busy_o     per-register pending-load map
//   err_o      sticky response-without-load error
interface wb_arbiter_if;
  import riscv_pkg::*;

  logic              ex_valid_i;
  logic              ex_ready_o;
  logic [REG_AW-1:0] ex_rd_i;
  wb_src_t           ex_sel_i;
  logic [XLEN-1:0]   ex_alu_i;
  logic [XLEN-1:0]   ex_ret_i;

  logic              ld_issue_valid_i;
  logic              ld_issue_ready_o;
  logic [REG_AW-1:0] ld_issue_rd_i;
  logic              ld_resp_valid_i;
  logic [XLEN-1:0]   ld_resp_data_i;

  logic              rf_we_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic [XLEN-1:0]   rf_wdata_o;
  logic [NREG-1:0]   busy_o;
  logic              err_o;

  modport slave (
    input  ex_valid_i, ex_rd_i, ex_sel_i, ex_alu_i, ex_ret_i,
    input  ld_issue_valid_i, ld_issue_rd_i, ld_resp_valid_i, ld_resp_data_i,
    output ex_ready_o, ld_issue_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, err_o
  );

  modport master (
    output ex_valid_i, ex_rd_i, ex_sel_i, ex_alu_i, ex_ret_i,
    output ld_issue_valid_i, ld_issue_rd_i, ld_resp_valid_i, ld_resp_data_i,
    input  ex_ready_o, ld_issue_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, err_o
  );

endinterface

// File: rtl/wb_tag_fifo.sv
// In-order queue of destination registers for outstanding loads.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   push_i         enqueue push_tag_i (caller guarantees !full_o)
//   push_tag_i     destination of the newly issued load
//   pop_i          dequeue the head (caller guarantees !empty_o)
//   head_o         destination of the oldest outstanding load
//   full_o/empty_o occupancy flags
//   busy_o         bit r set while any queued entry targets r; bit 0 forced 0
module wb_tag_fifo
  import riscv_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [REG_AW-1:0] push_tag_i,
  input  logic              pop_i,
  output logic [REG_AW-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [NREG-1:0]   busy_o
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra bit so full and empty differ only in that bit.
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     count;
  logic [REG_AW-1:0] mem [LQ_DEPTH];
  logic [AW-1:0]     idx;

  assign count   = wr_ptr - rd_ptr;
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PW'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr[AW-1:0]] <= push_tag_i;
  end

  // Walk the live window starting at the head; stale slots are ignored.
  always_comb begin
    busy_o = '0;
    idx    = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      idx = rd_ptr[AW-1:0] + AW'(i);
      if (PW'(i) < count) busy_o[mem[idx]] = 1'b1;
    end
    busy_o[0] = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Owner of the single register-file write port.
// Arbitrates between single-cycle execute results and in-order load responses.
// Load responses always win and never stall. Execute results are held off
// while a load response is present, or while their destination still has a
// load outstanding, which preserves write-after-write order.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous reset, active-high
//   bus    wb_arbiter_if.slave carrying the execute, load and rf signals
module wb_arbiter
  import riscv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  wb_arbiter_if.slave  bus
);

  logic              q_full;
  logic              q_empty;
  logic [REG_AW-1:0] q_head;
  logic              push;
  logic              pop;
  logic              ex_fire;

  // Push is refused whenever full, even if a pop happens in the same cycle.
  assign bus.ld_issue_ready_o = !q_full;
  assign push = bus.ld_issue_valid_i && !q_full;
  // A response with nothing queued is dropped, so it must not pop.
  assign pop  = bus.ld_resp_valid_i && !q_empty;

  assign bus.ex_ready_o = !bus.ld_resp_valid_i && !bus.busy_o[bus.ex_rd_i];
  assign ex_fire        = bus.ex_valid_i && bus.ex_ready_o;

  wb_tag_fifo u_tag_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_tag_i (bus.ld_issue_rd_i),
    .pop_i      (pop),
    .head_o     (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .busy_o     (bus.busy_o)
  );

  // Address/data hold when nothing writes; only the enable drops back to 0.
  // WB_MEM and the unused encoding are accepted on the execute port but
  // produce no write, because load data arrives through the response path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rf_we_o    <= 1'b0;
      bus.rf_waddr_o <= '0;
      bus.rf_wdata_o <= '0;
      bus.err_o      <= 1'b0;
    end else begin
      bus.rf_we_o <= 1'b0;
      if (bus.ld_resp_valid_i) begin
        if (q_empty) begin
          bus.err_o <= 1'b1;
        end else begin
          bus.rf_we_o    <= (q_head != '0);
          bus.rf_waddr_o <= q_head;
          bus.rf_wdata_o <= bus.ld_resp_data_i;
        end
      end else if (ex_fire) begin
        case (bus.ex_sel_i)
          WB_ALU: begin
            bus.rf_we_o    <= (bus.ex_rd_i != '0);
            bus.rf_waddr_o <= bus.ex_rd_i;
            bus.rf_wdata_o <= bus.ex_alu_i;
          end
          WB_PC_PLUS_FOUR: begin
            bus.rf_we_o    <= (bus.ex_rd_i != '0);
            bus.rf_waddr_o <= bus.ex_rd_i;
            bus.rf_wdata_o <= bus.ex_ret_i;
          end
          default: bus.rf_we_o <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Inputs change 1 time unit after a rising edge; registered outputs are
// checked after the following edge, combinational outputs before it.
module tb_wb_arbiter;
  import riscv_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ex_valid_i       = 1'b0;
    bus.ex_rd_i          = '0;
    bus.ex_sel_i         = WB_ALU;
    bus.ex_alu_i         = '0;
    bus.ex_ret_i         = '0;
    bus.ld_issue_valid_i = 1'b0;
    bus.ld_issue_rd_i    = '0;
    bus.ld_resp_valid_i  = 1'b0;
    bus.ld_resp_data_i   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", bus.rf_we_o); end
    checks++; if (bus.rf_waddr_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_waddr: got %0d expected 0", bus.rf_waddr_o); end
    checks++; if (bus.rf_wdata_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0000", bus.rf_wdata_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.err_o); end
    checks++; if (bus.busy_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 00000000", bus.busy_o); end
    checks++; if (bus.ld_issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_issue_ready: got %b expected 1", bus.ld_issue_ready_o); end
  endtask

  task automatic test_alu_write();
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 3'd3; bus.ex_sel_i = WB_ALU; bus.ex_alu_i = 16'h1234;
    #1;
    checks++; if (bus.ex_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL alu_ready: got %b expected 1", bus.ex_ready_o); end
    tick();
    bus.ex_valid_i = 1'b0;
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 3'd3, 16'h1234})
      begin errors++; $display("[TB] FAIL alu_write: got we=%b a=%0d d=%h expected we=1 a=3 d=1234", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    tick();
    checks++; if ({bus.rf_we_o, bus.rf_wdata_o} !== {1'b0, 16'h1234})
      begin errors++; $display("[TB] FAIL idle_hold: got we=%b d=%h expected we=0 d=1234", bus.rf_we_o, bus.rf_wdata_o); end
  endtask

  task automatic test_pc_plus_four();
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 3'd1; bus.ex_sel_i = WB_PC_PLUS_FOUR;
    bus.ex_alu_i = 16'hDEAD; bus.ex_ret_i = 16'h0042;
    tick();
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 3'd1, 16'h0042})
      begin errors++; $display("[TB] FAIL ret_write: got we=%b a=%0d d=%h expected we=1 a=1 d=0042", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    bus.ex_rd_i = 3'd0;
    tick();
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("[TB] FAIL ret_x0: got we=%b expected 0", bus.rf_we_o); end
    bus.ex_rd_i = 3'd6; bus.ex_sel_i = WB_MEM;
    tick();
    bus.ex_valid_i = 1'b0;
    checks++; if (bus.rf_we_o !== 1'b0) begin errors++; $display("[TB] FAIL mem_sel_no_write: got we=%b expected 0", bus.rf_we_o); end
  endtask

  task automatic test_load_order();
    bus.ld_issue_valid_i = 1'b1; bus.ld_issue_rd_i = 3'd2;
    tick();
    bus.ld_issue_rd_i = 3'd5;
    tick();
    bus.ld_issue_valid_i = 1'b0;
    checks++; if (bus.busy_o !== 8'b0010_0100) begin errors++; $display("[TB] FAIL busy_two: got %b expected 00100100", bus.busy_o); end
    bus.ld_resp_valid_i = 1'b1; bus.ld_resp_data_i = 16'hAAAA;
    tick();
    bus.ld_resp_data_i = 16'hBBBB;
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 3'd2, 16'hAAAA})
      begin errors++; $display("[TB] FAIL load_first: got we=%b a=%0d d=%h expected we=1 a=2 d=AAAA", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    checks++; if (bus.busy_o !== 8'b0010_0000) begin errors++; $display("[TB] FAIL busy_after_first: got %b expected 00100000", bus.busy_o); end
    tick();
    bus.ld_resp_valid_i = 1'b0;
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 3'd5, 16'hBBBB})
      begin errors++; $display("[TB] FAIL load_second: got we=%b a=%0d d=%h expected we=1 a=5 d=BBBB", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    checks++; if (bus.busy_o !== 8'h00) begin errors++; $display("[TB] FAIL busy_after_second: got %b expected 00000000", bus.busy_o); end
  endtask

  task automatic test_waw_stall();
    bus.ld_issue_valid_i = 1'b1; bus.ld_issue_rd_i = 3'd4;
    tick();
    bus.ld_issue_valid_i = 1'b0;
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 3'd4; bus.ex_sel_i = WB_ALU; bus.ex_alu_i = 16'h5555;
    #1;
    checks++; if (bus.ex_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL waw_stall: got ready=%b expected 0", bus.ex_ready_o); end
    tick();
    checks++; if ({bus.ex_ready_o, bus.rf_we_o} !== 2'b00) begin errors++; $display("[TB] FAIL waw_still_stalled: got ready=%b we=%b expected 0 0", bus.ex_ready_o, bus.rf_we_o); end
    bus.ld_resp_valid_i = 1'b1; bus.ld_resp_data_i = 16'h4444;
    tick();
    bus.ld_resp_valid_i = 1'b0;
    #1;
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 3'd4, 16'h4444})
      begin errors++; $display("[TB] FAIL waw_load_write: got we=%b a=%0d d=%h expected we=1 a=4 d=4444", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    checks++; if (bus.ex_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL waw_release: got ready=%b expected 1", bus.ex_ready_o); end
    tick();
    bus.ex_valid_i = 1'b0;
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 3'd4, 16'h5555})
      begin errors++; $display("[TB] FAIL waw_alu_write: got we=%b a=%0d d=%h expected we=1 a=4 d=5555", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
  endtask

  task automatic test_same_cycle();
    bus.ld_issue_valid_i = 1'b1; bus.ld_issue_rd_i = 3'd6;
    tick();
    bus.ld_issue_valid_i = 1'b0;
    bus.ld_resp_valid_i = 1'b1; bus.ld_resp_data_i = 16'h6666;
    bus.ex_valid_i = 1'b1; bus.ex_rd_i = 3'd1; bus.ex_sel_i = WB_ALU; bus.ex_alu_i = 16'h1111;
    #1;
    checks++; if (bus.ex_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL collide_ready: got %b expected 0", bus.ex_ready_o); end
    tick();
    bus.ld_resp_valid_i = 1'b0;
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 3'd6, 16'h6666})
      begin errors++; $display("[TB] FAIL collide_load: got we=%b a=%0d d=%h expected we=1 a=6 d=6666", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    tick();
    bus.ex_valid_i = 1'b0;
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 3'd1, 16'h1111})
      begin errors++; $display("[TB] FAIL collide_alu: got we=%b a=%0d d=%h expected we=1 a=1 d=1111", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
  endtask

  task automatic test_full_queue();
    bus.ld_issue_valid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.ld_issue_rd_i = 3'(i);
      tick();
    end
    bus.ld_issue_rd_i = 3'd7;
    #1;
    checks++; if (bus.ld_issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", bus.ld_issue_ready_o); end
    checks++; if (bus.busy_o !== 8'b0001_1110) begin errors++; $display("[TB] FAIL full_busy: got %b expected 00011110", bus.busy_o); end
    // Fifth issue coincides with a pop: still refused because the queue is full.
    bus.ld_resp_valid_i = 1'b1; bus.ld_resp_data_i = 16'h0101;
    tick();
    bus.ld_issue_valid_i = 1'b0;
    bus.ld_resp_valid_i = 1'b0;
    checks++; if ({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o} !== {1'b1, 3'd1, 16'h0101})
      begin errors++; $display("[TB] FAIL full_pop_write: got we=%b a=%0d d=%h expected we=1 a=1 d=0101", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
    checks++; if (bus.busy_o !== 8'b0001_1100) begin errors++; $display("[TB] FAIL refused_issue: got %b expected 00011100", bus.busy_o); end
    checks++; if (bus.ld_issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_pop: got %b expected 1", bus.ld_issue_ready_o); end
  endtask

  task automatic test_error();
    do_reset();
    checks++; if (bus.busy_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_discards_tags: got %b expected 00000000", bus.busy_o); end
    bus.ld_resp_valid_i = 1'b1; bus.ld_resp_data_i = 16'hEEEE;
    tick();
    bus.ld_resp_valid_i = 1'b0;
    checks++; if ({bus.err_o, bus.rf_we_o} !== 2'b10) begin errors++; $display("[TB] FAIL empty_resp: got err=%b we=%b expected 1 0", bus.err_o, bus.rf_we_o); end
    tick();
    tick();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", bus.err_o); end
    do_reset();
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected 0", bus.err_o); end
    // Push and response together on an empty queue: error, no write, push kept.
    bus.ld_issue_valid_i = 1'b1; bus.ld_issue_rd_i = 3'd3;
    bus.ld_resp_valid_i = 1'b1; bus.ld_resp_data_i = 16'h3333;
    tick();
    clear_inputs();
    checks++; if ({bus.err_o, bus.rf_we_o} !== 2'b10) begin errors++; $display("[TB] FAIL push_resp_empty: got err=%b we=%b expected 1 0", bus.err_o, bus.rf_we_o); end
    checks++; if (bus.busy_o !== 8'b0000_1000) begin errors++; $display("[TB] FAIL push_kept: got %b expected 00001000", bus.busy_o); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_alu_write();
    test_pc_plus_four();
    test_load_order();
    test_waw_stall();
    test_same_cycle();
    test_full_queue();
    test_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
